// File: rtl/hr_pkg.sv
// Shared types and constants for the heart-rate interval averager and its divider.
package hr_pkg;

  typedef enum logic [1:0] {StIdle, StAcquire, StTrack, StDivide} hr_state_e;

  localparam int unsigned SAMPLE_RATE_DEF = 100;
  localparam int unsigned AVG_DEPTH_DEF   = 4;

  function automatic int unsigned bpm_num(input int unsigned rate, input int unsigned depth);
    return 60 * rate * depth;
  endfunction

  // Bits needed to hold values 0..n
  function automatic int unsigned num_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned BPM_NUM = bpm_num(SAMPLE_RATE_DEF, AVG_DEPTH_DEF);

endpackage

// File: rtl/hr_seq_divider.sv
// Start/done restoring unsigned divider, one quotient bit per clock, with synchronous abort.
module hr_seq_divider #(
  parameter int unsigned NumW = 15,
  parameter int unsigned DenW = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [NumW-1:0] numer,
  input  logic [DenW-1:0] denom,
  output logic [NumW-1:0] quot,
  output logic            done
);
  localparam int unsigned CntW = $clog2(NumW + 1);

  logic            busy_q, busy_d, done_q, done_d, fits;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NumW-1:0] num_q, num_d;
  logic [DenW-1:0] rem_q, rem_d, den_q, den_d;
  logic [DenW:0]   trial;

  // num_q shifts dividend bits out of the top and quotient bits in at the bottom
  always_comb begin
    trial  = {rem_q, num_q[NumW-1]};
    fits   = trial >= {1'b0, den_q};
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    num_d  = num_q;
    rem_d  = rem_q;
    den_d  = den_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(NumW);
      num_d  = numer;
      rem_d  = '0;
      den_d  = denom;
    end else if (busy_q) begin
      num_d = {num_q[NumW-2:0], fits};
      rem_d = fits ? DenW'(trial - {1'b0, den_q}) : trial[DenW-1:0];
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      num_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
    end
  end

  assign quot = num_q;
  assign done = done_q;

endmodule

// File: rtl/hr_interval_averager.sv
// Beat-interval averager: gates refractory peaks, averages AVG_DEPTH intervals, divides to BPM.
// Optional OUTLIER_REJECT_EN: once hr_valid, drop intervals outside [avg/2, 2*avg].
module hr_interval_averager
  import hr_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = 100,
  parameter int unsigned AVG_DEPTH   = 4,
  parameter int unsigned REFRACT     = 25,
  parameter int unsigned TIMEOUT     = 300,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       peak,
  output logic [7:0] hr,
  output logic       hr_valid,
  output logic       beat,
  output logic       no_signal
);
  localparam int unsigned PtrW   = $clog2(AVG_DEPTH);
  localparam int unsigned FillW  = $clog2(AVG_DEPTH + 1);
  localparam int unsigned SumW   = CNT_W + PtrW;
  localparam int unsigned BpmNum = bpm_num(SAMPLE_RATE, AVG_DEPTH);
  localparam int unsigned NumW   = num_width(BpmNum);
  localparam logic [CNT_W-1:0] RefractC = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [FillW-1:0] FullC    = FillW'(AVG_DEPTH);

  hr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pend_val_q, pend_val_d, write_val;
  logic [CNT_W-1:0] ring_q [AVG_DEPTH];
  logic [CNT_W-1:0] ring_d [AVG_DEPTH];
  logic [SumW-1:0]  sum_q, sum_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FillW-1:0] fill_q, fill_d, fill_inc;
  logic [7:0]       hr_q, hr_d;
  logic             hr_valid_q, hr_valid_d, beat_q, beat_d, no_signal_q, no_signal_d;
  logic             pend_q, pend_d, start_q, start_d;
  logic [NumW-1:0]  quot;
  logic             div_done, tracking, timeout, anchor, in_window, outlier, accept;
  logic             write_en, full_after;

`ifdef OUTLIER_REJECT_EN
  logic [SumW:0] ivl_w, avg_w;
  always_comb begin
    ivl_w   = (SumW + 1)'(cnt_q);
    avg_w   = (SumW + 1)'(sum_q >> PtrW);
    outlier = hr_valid_q && (((ivl_w << 1) < avg_w) || (ivl_w > (avg_w << 1)));
  end
`else
  assign outlier = 1'b0;
`endif

  always_comb begin
    tracking  = (state_q != StIdle);
    timeout   = tracking && (cnt_q == TimeoutC);
    anchor    = peak && (state_q == StIdle);
    in_window = peak && tracking && (cnt_q >= RefractC) && (cnt_q < TimeoutC);
    accept    = in_window && !outlier;
    write_en  = 1'b0;
    write_val = cnt_q;
    // A finishing divide retires the pending interval first, else a same-cycle peak
    if (state_q == StDivide) begin
      if (div_done) begin
        write_en  = pend_q || accept;
        write_val = pend_q ? pend_val_q : cnt_q;
      end
    end else if (tracking) begin
      write_en = accept;
    end
    fill_inc   = (fill_q == FullC) ? fill_q : fill_q + FillW'(1);
    full_after = (fill_inc == FullC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:            if (anchor) state_d = StAcquire;
      StAcquire, StTrack: begin
        if (timeout)                      state_d = StIdle;
        else if (write_en && full_after)  state_d = StDivide;
      end
      StDivide: begin
        if (timeout)       state_d = StIdle;
        else if (div_done) state_d = write_en ? StDivide : StTrack;
      end
      default:           state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    ring_d      = ring_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    hr_d        = hr_q;
    hr_valid_d  = hr_valid_q;
    no_signal_d = no_signal_q;
    beat_d      = accept;
    start_d     = write_en && full_after;
    if (anchor || in_window)                          cnt_d = sample_tick ? CNT_W'(1) : '0;
    else if (tracking && sample_tick && !timeout)     cnt_d = cnt_q + CNT_W'(1);
    if (anchor) no_signal_d = 1'b0;
    if (state_q == StDivide) begin
      if (div_done)                 pend_d = pend_q && accept;
      else if (accept && !pend_q)   pend_d = 1'b1;
      if (accept && (div_done || !pend_q)) pend_val_d = cnt_q;
      if (div_done) begin
        hr_d       = (quot > NumW'(255)) ? 8'd255 : quot[7:0];
        hr_valid_d = 1'b1;
      end
    end
    if (write_en) begin
      ring_d[wr_ptr_q] = write_val;
      sum_d            = sum_q + SumW'(write_val) - SumW'(ring_q[wr_ptr_q]);
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
      fill_d           = fill_inc;
    end
    if (timeout) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring_d[i] = '0;
      cnt_d       = '0;
      sum_d       = '0;
      wr_ptr_d    = '0;
      fill_d      = '0;
      pend_d      = 1'b0;
      hr_d        = '0;
      hr_valid_d  = 1'b0;
      no_signal_d = 1'b1;
      start_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      hr_q        <= '0;
      hr_valid_q  <= 1'b0;
      beat_q      <= 1'b0;
      no_signal_q <= 1'b1;
      start_q     <= 1'b0;
    end else begin
      ring_q      <= ring_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      hr_q        <= hr_d;
      hr_valid_q  <= hr_valid_d;
      beat_q      <= beat_d;
      no_signal_q <= no_signal_d;
      start_q     <= start_d;
    end
  end

  hr_seq_divider #(
    .NumW(NumW),
    .DenW(SumW)
  ) u_div (
    .clock(clock),
    .reset(reset),
    .start(start_q),
    .abort(timeout),
    .numer(NumW'(BpmNum)),
    .denom(sum_q),
    .quot (quot),
    .done (div_done)
  );

  assign hr        = hr_q;
  assign hr_valid  = hr_valid_q;
  assign beat      = beat_q;
  assign no_signal = no_signal_q;

endmodule

// File: tb/tb_hr_interval_averager.sv
// Directed bench for hr_interval_averager; REFRACT lowered so a peak can land mid-divide.
module tb_hr_interval_averager;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       peak = 1'b0;
  logic [7:0] hr;
  logic       hr_valid, beat, no_signal;
  int         total = 0;
  int         bad = 0;

  hr_interval_averager #(
    .SAMPLE_RATE(100),
    .AVG_DEPTH  (4),
    .REFRACT    (10),
    .TIMEOUT    (300),
    .CNT_W      (11)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sample_tick(sample_tick),
    .peak       (peak),
    .hr         (hr),
    .hr_valid   (hr_valid),
    .beat       (beat),
    .no_signal  (no_signal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      sample_tick = 1'b0;
      peak = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clock);
      sample_tick = 1'b1;
      peak = 1'b0;
    end
  endtask

  task automatic pulse(output logic b);
    @(negedge clock);
    sample_tick = 1'b0;
    peak = 1'b1;
    @(negedge clock);
    peak = 1'b0;
    b = beat;
  endtask

  task automatic beat_after(input int n, input logic exp, input string tag);
    logic b;
    ticks(n);
    pulse(b);
    check(tag, 32'(b), 32'(exp));
  endtask

  initial begin
    logic b;
    idle(3);
    check("rst_hr", 32'(hr), 32'd0);
    check("rst_valid", 32'(hr_valid), 32'd0);
    check("rst_beat", 32'(beat), 32'd0);
    check("rst_nosig", 32'(no_signal), 32'd1);
    reset = 1'b0;

    // Five peaks 75 ticks apart: anchor then four beats, 24000/300
    pulse(b);
    check("anchor_beat", 32'(b), 32'd0);
    check("anchor_nosig", 32'(no_signal), 32'd0);
    repeat (4) beat_after(75, 1'b1, "t1_beat");
    idle(30);
    check("t1_hr", 32'(hr), 32'd80);
    check("t1_valid", 32'(hr_valid), 32'd1);

    // Refractory peak is ignored and does not restart the interval
    beat_after(5, 1'b0, "t3_refract_ignored");
    beat_after(70, 1'b1, "t3_next_beat");
    idle(30);
    check("t3_hr", 32'(hr), 32'd80);

    // One 60-tick interval: 24000/285
    beat_after(60, 1'b1, "t2_beat");
    idle(30);
    check("t2_hr", 32'(hr), 32'd84);
    check("t2_nosig", 32'(no_signal), 32'd0);

    repeat (4) beat_after(75, 1'b1, "restore_beat");
    idle(30);
    check("restore_hr", 32'(hr), 32'd80);

    // 160-tick interval
`ifdef OUTLIER_REJECT_EN
    beat_after(160, 1'b0, "t6_outlier_beat");
    idle(30);
    check("t6_outlier_hr", 32'(hr), 32'd80);
`else
    beat_after(160, 1'b1, "t6_long_beat");
    idle(30);
    check("t6_long_hr", 32'(hr), 32'd62);
`endif

    // Timeout boundary: 299 ticks is still tracking, 300 drops the signal
    ticks(299);
    idle(1);
    check("t4_pre_nosig", 32'(no_signal), 32'd0);
    check("t4_pre_valid", 32'(hr_valid), 32'd1);
    ticks(1);
    idle(2);
    check("t4_hr", 32'(hr), 32'd0);
    check("t4_valid", 32'(hr_valid), 32'd0);
    check("t4_nosig", 32'(no_signal), 32'd1);
    pulse(b);
    check("t4_reanchor_beat", 32'(b), 32'd0);
    check("t4_reanchor_nosig", 32'(no_signal), 32'd0);
    beat_after(75, 1'b1, "t4_first_beat");
    idle(30);
    check("t4_refill_valid", 32'(hr_valid), 32'd0);
    check("t4_refill_hr", 32'(hr), 32'd0);

    // Peak during the divide is held pending, then applied: 24000/237
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    pulse(b);
    repeat (4) beat_after(75, 1'b1, "t5_fill_beat");
    beat_after(12, 1'b1, "t5_pending_beat");
    idle(60);
    check("t5_pending_hr", 32'(hr), 32'd101);
    check("t5_pending_valid", 32'(hr_valid), 32'd1);

    // Reset mid-division clears outputs at once and no late result appears
    beat_after(75, 1'b1, "t5_div_beat");
    idle(5);
    #1 reset = 1'b1;
    #1;
    check("t5_async_hr", 32'(hr), 32'd0);
    check("t5_async_valid", 32'(hr_valid), 32'd0);
    check("t5_async_nosig", 32'(no_signal), 32'd1);
    idle(2);
    reset = 1'b0;
    idle(30);
    check("t5_abort_hr", 32'(hr), 32'd0);
    check("t5_abort_valid", 32'(hr_valid), 32'd0);

    // REFRACT boundary and quotient saturation: 24000/40 = 600 -> 255
    pulse(b);
    beat_after(9, 1'b0, "refract_minus1");
    beat_after(1, 1'b1, "refract_exact");
    repeat (3) beat_after(10, 1'b1, "sat_beat");
    idle(30);
    check("sat_hr", 32'(hr), 32'd255);
    check("sat_valid", 32'(hr_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
